// File: rtl/net_inject_adapter_if.sv
// Request side and both ring-injection ports of the net inject adapter.
// The slave modport is the adapter itself.
interface net_inject_adapter_if #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3
);
  localparam int m = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits;

  logic                       req_val;
  logic                       req_rdy;
  logic                       req_domain;
  logic [p_srcdest_nbits-1:0] req_dest;
  logic [p_payload_nbits-1:0] req_payload;

  logic                       out_val_d0;
  logic                       out_rdy_d0;
  logic [m-1:0]               out_msg_d0;
  logic                       out_val_d1;
  logic                       out_rdy_d1;
  logic [m-1:0]               out_msg_d1;

  logic [7:0]                 err_count;

  modport master (
    output req_val, req_domain, req_dest, req_payload, out_rdy_d0, out_rdy_d1,
    input  req_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1, err_count
  );

  modport slave (
    input  req_val, req_domain, req_dest, req_payload, out_rdy_d0, out_rdy_d1,
    output req_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1, err_count
  );
endinterface

// File: rtl/net_inject_adapter.sv
// Formats requests into ring messages and queues them in one 2-entry FIFO per
// security domain; out-of-range destinations are dropped and counted.
module net_inject_adapter #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8
) (
  input logic               clk,
  input logic               reset,
  net_inject_adapter_if.slave ifc
);
  localparam int m = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits;
  localparam logic [p_srcdest_nbits-1:0] c_src = p_srcdest_nbits'(p_router_id);

  logic [1:0]   full;
  logic [1:0]   out_val;
  logic [1:0]   out_rdy;
  logic [m-1:0] head [2];
  logic         dest_ok;
  logic         req_fire;
  logic         accept;
  logic         reject;
  logic [7:0]   err_count_reg;

  // Ready looks only at the addressed domain, so the two domains never stall each other.
  assign ifc.req_rdy = !full[ifc.req_domain];
  assign dest_ok     = 32'(ifc.req_dest) < p_num_routers;
  assign req_fire    = ifc.req_val && ifc.req_rdy;
  assign accept      = req_fire && dest_ok;
  assign reject      = req_fire && !dest_ok;

  assign out_rdy[0]     = ifc.out_rdy_d0;
  assign out_rdy[1]     = ifc.out_rdy_d1;
  assign ifc.out_val_d0 = out_val[0];
  assign ifc.out_val_d1 = out_val[1];
  assign ifc.out_msg_d0 = head[0];
  assign ifc.out_msg_d1 = head[1];
  assign ifc.err_count  = err_count_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dom
    logic [m-1:0]                mem_reg [2];
    logic                        wr_ptr_reg;
    logic                        rd_ptr_reg;
    logic [1:0]                  count_reg;
    logic [p_opaque_nbits-1:0]   opaque_reg;
    logic                        enq;
    logic                        deq;

    assign enq         = accept && (ifc.req_domain == 1'(gi));
    assign deq         = out_val[gi] && out_rdy[gi];
    assign full[gi]    = (count_reg == 2'd2);
    assign out_val[gi] = (count_reg != 2'd0);
    assign head[gi]    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
      if (enq) begin
        mem_reg[wr_ptr_reg] <= {ifc.req_dest, c_src, opaque_reg, ifc.req_payload};
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
        count_reg  <= 2'd0;
        opaque_reg <= '0;
      end else begin
        if (enq) begin
          wr_ptr_reg <= ~wr_ptr_reg;
          opaque_reg <= opaque_reg + p_opaque_nbits'(1);
        end
        if (deq) begin
          rd_ptr_reg <= ~rd_ptr_reg;
        end
        count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count_reg <= 8'd0;
    end else if (reject && (err_count_reg != 8'hff)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end
endmodule

// File: tb/tb_net_inject_adapter.sv
// Scoreboard bench for net_inject_adapter: a driver pushes expected messages
// per domain, a negedge monitor pops and compares whatever the DUT presents.
module tb_net_inject_adapter;
  localparam int P   = 32;
  localparam int O   = 3;
  localparam int S   = 3;
  localparam int RID = 2;
  localparam int NR  = 6;
  localparam int M   = P + O + 2 * S;

  typedef logic [M-1:0] msg_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  net_inject_adapter_if #(.p_payload_nbits(P), .p_opaque_nbits(O), .p_srcdest_nbits(S)) ifc ();

  net_inject_adapter #(
    .p_payload_nbits(P), .p_opaque_nbits(O), .p_srcdest_nbits(S),
    .p_router_id(RID), .p_num_routers(NR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ifc(ifc)
  );

  msg_t        q [2][$];
  logic [O-1:0] opq [2];
  int          err_m = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  bit          done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle of stimulus; starts shortly after a rising edge, returns on the next one.
  task automatic step(input bit v, input bit d, input logic [S-1:0] dst, input logic [P-1:0] pl,
                      input bit r0, input bit r1, input bit rn);
    bit exp_rdy;
    #1;
    ifc.req_val     = v;
    ifc.req_domain  = d;
    ifc.req_dest    = dst;
    ifc.req_payload = pl;
    ifc.out_rdy_d0  = r0;
    ifc.out_rdy_d1  = r1;
    reset           = rn;
    #1;
    exp_rdy = (q[d].size() < 2);
    if (rn && mon_en) chk("req_rdy", 64'(ifc.req_rdy), 64'(exp_rdy));
    @(posedge clk);
    if (!rn) begin
      q[0].delete();
      q[1].delete();
      opq[0] = '0;
      opq[1] = '0;
      err_m  = 0;
      if (mon_en) $display("txn reset t=%0t", $time);
    end else if (v && exp_rdy) begin
      if (32'(dst) < NR) begin
        q[d].push_back({dst, S'(RID), opq[d], pl});
        $display("txn accept dom=%0d dest=%0d opaque=%0d payload=%h", d, dst, opq[d], pl);
        opq[d] = O'(opq[d] + 1);
      end else begin
        if (err_m < 255) err_m++;
        $display("txn discard dom=%0d dest=%0d payload=%h", d, dst, pl);
      end
    end else if (v) begin
      $display("txn stalled dom=%0d dest=%0d", d, dst);
    end
  endtask

  task automatic send(input bit d, input logic [S-1:0] dst, input bit r0, input bit r1);
    step(1'b1, d, dst, $urandom, r0, r1, 1'b1);
  endtask

  task automatic idle(input bit r0, input bit r1);
    step(1'b0, 1'b0, 3'd0, 32'd0, r0, r1, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'd3, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: checks presented outputs against the scoreboard heads.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          logic v;
          logic r;
          msg_t mm;
          v  = (d == 1) ? ifc.out_val_d1 : ifc.out_val_d0;
          r  = (d == 1) ? ifc.out_rdy_d1 : ifc.out_rdy_d0;
          mm = (d == 1) ? ifc.out_msg_d1 : ifc.out_msg_d0;
          chk($sformatf("out_val_d%0d", d), 64'(v), 64'(q[d].size() != 0));
          if (v === 1'b1 && q[d].size() != 0) begin
            chk($sformatf("out_msg_d%0d", d), 64'(mm), 64'(q[d][0]));
            if (r) void'(q[d].pop_front());
          end
        end
        chk("err_count", 64'(ifc.err_count), 64'(err_m));
      end
    end
  end

  initial begin
    opq[0] = '0;
    opq[1] = '0;
    ifc.req_val = 1'b0; ifc.req_domain = 1'b0; ifc.req_dest = '0; ifc.req_payload = '0;
    ifc.out_rdy_d0 = 1'b0; ifc.out_rdy_d1 = 1'b0;
    do_reset();
    do_reset();
    mon_en = 1'b1;
    #1 chk("reset_val_d0", 64'(ifc.out_val_d0), 64'd0);
    chk("reset_val_d1", 64'(ifc.out_val_d1), 64'd0);
    chk("reset_rdy", 64'(ifc.req_rdy), 64'd1);

    // Single send to dest 5
    step(1'b1, 1'b0, 3'd5, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
    #1 chk("single_msg", 64'(ifc.out_msg_d0), 64'({3'd5, 3'd2, 3'd0, 32'hCAFEF00D}));
    chk("single_val_d1", 64'(ifc.out_val_d1), 64'd0);
    idle(1'b1, 1'b0);

    // Back-pressure on domain 1
    repeat (3) send(1'b1, 3'd1, 1'b0, 1'b0);
    #1 ifc.req_domain = 1'b1;
    #1 chk("bp_rdy_d1", 64'(ifc.req_rdy), 64'd0);
    ifc.req_domain = 1'b0;
    #1 chk("bp_rdy_d0", 64'(ifc.req_rdy), 64'd1);
    idle(1'b0, 1'b1);
    #1 chk("bp_second_opaque", 64'(ifc.out_msg_d1[P+O-1:P]), 64'd1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // Opaque wrap on domain 0; domain 1 untouched
    do_reset();
    repeat (9) send(1'b0, 3'($urandom_range(0, NR - 1)), 1'b1, 1'b0);
    send(1'b1, 3'd3, 1'b1, 1'b0);
    #1 chk("d1_opaque_zero", 64'(ifc.out_msg_d1[P+O-1:P]), 64'd0);
    idle(1'b1, 1'b1);

    // Bad destination and err_count saturation
    do_reset();
    send(1'b0, 3'd7, 1'b0, 1'b0);
    #1 chk("bad_err_one", 64'(ifc.err_count), 64'd1);
    chk("bad_no_val", 64'(ifc.out_val_d0), 64'd0);
    send(1'b0, 3'd2, 1'b0, 1'b0);
    #1 chk("after_bad_opaque", 64'(ifc.out_msg_d0[P+O-1:P]), 64'd0);
    idle(1'b1, 1'b0);
    repeat (300) send(1'($urandom_range(0, 1)), 3'(NR + $urandom_range(0, 1)), 1'b0, 1'b0);
    #1 chk("err_saturate", 64'(ifc.err_count), 64'd255);

    // Reset with both FIFOs full and a request in the reset cycle
    repeat (2) send(1'b0, 3'd1, 1'b0, 1'b0);
    repeat (2) send(1'b1, 3'd1, 1'b0, 1'b0);
    do_reset();
    #1 chk("midrst_val_d0", 64'(ifc.out_val_d0), 64'd0);
    chk("midrst_val_d1", 64'(ifc.out_val_d1), 64'd0);
    chk("midrst_err", 64'(ifc.err_count), 64'd0);
    send(1'b0, 3'd4, 1'b0, 1'b0);
    #1 chk("midrst_opaque", 64'(ifc.out_msg_d0[P+O-1:P]), 64'd0);

    // Simultaneous enqueue and dequeue with one entry buffered
    send(1'b0, 3'd5, 1'b1, 1'b0);
    #1 chk("simul_opaque", 64'(ifc.out_msg_d0[P+O-1:P]), 64'd1);
    send(1'b0, 3'd0, 1'b0, 1'b0);
    send(1'b0, 3'd0, 1'b0, 1'b0);
    repeat (3) idle(1'b1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) != 0));
    end

    // Bounded drain
    repeat (8) idle(1'b1, 1'b1);
    #1 chk("drain_val_d0", 64'(ifc.out_val_d0), 64'd0);
    chk("drain_val_d1", 64'(ifc.out_val_d1), 64'd0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/net_inject_adapter.md
NET_INJECT_ADAPTER -- requirements
Module: plab4_net_NetInjectAdapter

Interface
REQ-001 SHALL have parameter p_payload_nbits, default 32, payload width p.
REQ-002 SHALL have parameter p_opaque_nbits, default 3, opaque width o.
REQ-003 SHALL have parameter p_srcdest_nbits, default 3, src/dest width s.
REQ-004 SHALL have parameter p_router_id, default 0, terminal id written into the src field.
REQ-005 SHALL have parameter p_num_routers, default 8, number of ring terminals.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-008 SHALL have port req_val, input, 1, request valid.
REQ-009 SHALL have port req_rdy, output, 1, request ready.
REQ-010 SHALL have port req_domain, input, 1, security domain (0 = d0, 1 = d1).
REQ-011 SHALL have port req_dest, input, s, destination terminal.
REQ-012 SHALL have port req_payload, input, p, payload.
REQ-013 SHALL have ports out_val_d0 / out_rdy_d0 / out_msg_d0: output 1 / input 1 / output m (m = p+o+2s); domain-0 injection into the ring's in_*_d0 terminal port.
REQ-014 SHALL have ports out_val_d1 / out_rdy_d1 / out_msg_d1, same widths as REQ-013; domain-1 injection.
REQ-015 SHALL have port err_count, output, 8, count of rejected requests.

Function
REQ-016 SHALL format out_msg as {dest[m-1:m-s], src[m-s-1:m-2s], opaque[p+o-1:p], payload[p-1:0]}; src = p_router_id.
REQ-017 SHALL contain one 2-entry FIFO per domain, no bypass path; enqueued entry visible on out_val_dX the cycle after enqueue.
REQ-018 SHALL drive req_rdy = !full(FIFO[req_domain]), combinationally from req_domain; a full FIFO blocks enqueue even when a dequeue occurs in the same cycle.
REQ-019 SHALL accept a request iff req_val && req_rdy && req_dest < p_num_routers.
REQ-020 SHALL, when req_val && req_rdy && req_dest >= p_num_routers, consume and discard the request (no enqueue, no opaque advance) and increment err_count.
REQ-021 SHALL saturate err_count at 255.
REQ-022 SHALL keep one o-bit opaque sequence counter per domain; an accepted request takes the current value, then the counter increments by 1 mod 2^o (7 wraps to 0 for o = 3).
REQ-023 SHALL drive out_val_dX = FIFO[X] non-empty and out_msg_dX = head entry; dequeue when out_val_dX && out_rdy_dX.
REQ-024 SHALL keep entries in order within a domain; the domains are fully independent (no shared state, no cross-domain stall), so neither domain's timing depends on the other's.
REQ-025 SHALL support a same-cycle enqueue and dequeue on a non-full FIFO: occupancy unchanged, order preserved.
REQ-026 SHALL hold out_msg_dX stable while out_val_dX && !out_rdy_dX.
REQ-027 SHALL have zero-cycle request-to-ready latency and one-cycle request-to-out_val latency when the FIFO is empty.

Reset
REQ-028 SHALL, while reset == 0 at a clk edge, clear both FIFOs, both opaque counters and err_count to 0.
REQ-029 SHALL drive out_val_d0 = out_val_d1 = 0 and req_rdy = 1 in the cycle after reset; out_msg content is don't-care when out_val = 0.
REQ-030 SHALL, on reset asserted mid-operation, discard all buffered entries with no partial output; no message is emitted for a request presented in the same cycle as reset.

Verification
REQ-031 Single send: after reset, domain 0, dest 5, payload 0xCAFEF00D, p_router_id 2 -> next cycle out_val_d0 = 1, out_msg_d0 = {3'd5, 3'd2, 3'd0, 32'hCAFEF00D}; out_val_d1 = 0.
REQ-032 Back-pressure: out_rdy_d1 = 0, three domain-1 requests -> first two accepted, req_rdy = 0 for the third while req_domain = 1, req_rdy = 1 for domain 0; raising out_rdy_d1 drains the two entries in order, opaque 0 then 1.
REQ-033 Opaque wrap: 9 accepted domain-0 requests -> opaque fields 0..7,0; domain-1 counter still 0.
REQ-034 Bad dest: dest 7 with p_num_routers = 6 -> err_count = 1, no out_val, next valid request carries opaque 0; 300 bad requests -> err_count = 255.
REQ-035 Reset mid-flight: both FIFOs full, reset = 0 for one cycle -> out_val_d0 = out_val_d1 = 0, err_count = 0, next request gets opaque 0.
REQ-036 Simultaneous: one domain-0 entry buffered, out_rdy_d0 = 1 with a new domain-0 request in the same cycle -> old entry dequeued, new entry appears next cycle, occupancy stays 1.
